// File: rtl/encoder_stream_collector.sv
// Drains the three encoder subblock streams byte by byte and serialises each triple onto one
// tagged valid/ready byte stream. Optional trailing XOR checksum under COLLECTOR_CHECKSUM_EN.
module encoder_stream_collector #(
    parameter int unsigned LEN0_BYTES = 132,
    parameter int unsigned LEN1_BYTES = 768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       computation_done,
    input  logic       length_in,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    output logic       rdreq_subblock,
    output logic [7:0] out_data,
    output logic [1:0] out_stream,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       blk_done
);

`ifdef COLLECTOR_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StReq, StCap, StS0, StS1, StS2, StDone, StChk
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StReq, StCap, StS0, StS1, StS2, StDone
    } state_e;
`endif

    localparam logic [9:0] Len0Last = 10'(LEN0_BYTES - 1);
    localparam logic [9:0] Len1Last = 10'(LEN1_BYTES - 1);

    state_e     state_q, state_d;
    logic       armed_q, armed_d;
    logic       len_sel_q, len_sel_d;
    logic [9:0] bcnt_q, bcnt_d;
    logic [7:0] h0_q, h0_d;
    logic [7:0] h1_q, h1_d;
    logic [7:0] h2_q, h2_d;
    logic       last_byte;
`ifdef COLLECTOR_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
`endif

    assign last_byte = (bcnt_q == (len_sel_q ? Len1Last : Len0Last));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            armed_q   <= 1'b1;
            len_sel_q <= 1'b0;
            bcnt_q    <= '0;
            h0_q      <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
`ifdef COLLECTOR_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            len_sel_q <= len_sel_d;
            bcnt_q    <= bcnt_d;
            h0_q      <= h0_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
`ifdef COLLECTOR_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        len_sel_d = len_sel_q;
        bcnt_d    = bcnt_q;
        h0_d      = h0_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
`ifdef COLLECTOR_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        // A low level re-arms; finishing a block disarms so a held level cannot retrigger.
        if (!computation_done) begin
            armed_d = 1'b1;
        end else if (state_q == StDone) begin
            armed_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (computation_done && armed_q) begin
                    len_sel_d = length_in;
                    bcnt_d    = '0;
`ifdef COLLECTOR_CHECKSUM_EN
                    xor_d     = '0;
`endif
                    state_d   = StReq;
                end
            end
            StReq: state_d = StCap;
            StCap: begin
                h0_d    = q0;
                h1_d    = q1;
                h2_d    = q2;
                state_d = StS0;
            end
            StS0: begin
                if (out_ready) begin
`ifdef COLLECTOR_CHECKSUM_EN
                    xor_d = xor_q ^ h0_q;
`endif
                    state_d = StS1;
                end
            end
            StS1: begin
                if (out_ready) begin
`ifdef COLLECTOR_CHECKSUM_EN
                    xor_d = xor_q ^ h1_q;
`endif
                    state_d = StS2;
                end
            end
            StS2: begin
                if (out_ready) begin
`ifdef COLLECTOR_CHECKSUM_EN
                    xor_d = xor_q ^ h2_q;
`endif
                    bcnt_d = bcnt_q + 10'd1;
                    if (last_byte) begin
`ifdef COLLECTOR_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StReq;
                    end
                end
            end
`ifdef COLLECTOR_CHECKSUM_EN
            StChk: begin
                if (out_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs
    always_comb begin
        rdreq_subblock = 1'b0;
        out_data       = '0;
        out_stream     = 2'd0;
        out_valid      = 1'b0;
        out_last       = 1'b0;
        blk_done       = 1'b0;
        case (state_q)
            StReq: rdreq_subblock = 1'b1;
            StS0: begin
                out_valid  = 1'b1;
                out_data   = h0_q;
                out_stream = 2'd0;
            end
            StS1: begin
                out_valid  = 1'b1;
                out_data   = h1_q;
                out_stream = 2'd1;
            end
            StS2: begin
                out_valid  = 1'b1;
                out_data   = h2_q;
                out_stream = 2'd2;
`ifndef COLLECTOR_CHECKSUM_EN
                out_last   = last_byte;
`endif
            end
`ifdef COLLECTOR_CHECKSUM_EN
            StChk: begin
                out_valid  = 1'b1;
                out_data   = xor_q;
                out_stream = 2'd3;
                out_last   = 1'b1;
            end
`endif
            StDone:  blk_done = 1'b1;
            default: ;
        endcase
    end

endmodule
